serial_subtractor: RTL and testbench

Bit-serial subtractor computing `a - b - bIn` one bit per clock, LSB first, with a start/done handshake. It is the inverse-direction companion to the team's combinational 4-bit ripple adder. It handles narrow-datapath subtraction where area matters more than latency, and it serves as the reference structure for later multi-cycle arithmetic blocks.

---
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bIn one bit per clock, LSB first,
// with a start/done handshake and registered diff/bOut.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bIn,
  output logic [WIDTH-1:0] diff,
  output logic             bOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  // Holds the WIDTH-1 bits already produced; the final bit joins them on the last edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bOut_q, bOut_d;

  logic             accept;
  logic             lastBit;
  logic             dBit;
  logic             brNext;
  logic [WIDTH-1:0] resFull;

  assign accept  = start && ((state_q == StIdle) || (state_q == StDone));
  assign lastBit = (cnt_q == LastBit);
  assign dBit    = aSr_q[0] ^ bSr_q[0] ^ br_q;
  assign brNext  = (~aSr_q[0] & bSr_q[0]) | (~(aSr_q[0] ^ bSr_q[0]) & br_q);
  assign resFull = {dBit, res_q};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = start ? StShift : StIdle;
      StShift: state_d = lastBit ? StDone : StShift;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    diff = diff_q;
    bOut = bOut_q;
  end

  // Datapath next-state
  always_comb begin
    aSr_d  = aSr_q;
    bSr_d  = bSr_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    diff_d = diff_q;
    bOut_d = bOut_q;
    if (accept) begin
      aSr_d = a;
      bSr_d = b;
      br_d  = bIn;
      res_d = '0;
      cnt_d = '0;
    end else if (state_q == StShift) begin
      aSr_d = aSr_q >> 1;
      bSr_d = bSr_q >> 1;
      br_d  = brNext;
      res_d = resFull[WIDTH-1:1];
      cnt_d = cnt_q + CntW'(1);
      if (lastBit) begin
        diff_d = resFull;
        bOut_d = brNext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aSr_q  <= '0;
      bSr_q  <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bOut_q <= 1'b0;
    end else begin
      aSr_q  <= aSr_d;
      bSr_q  <= bSr_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      diff_q <= diff_d;
      bOut_q <= bOut_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed handshake cases, random
// operands and an exhaustive operand sweep against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bIn;
  logic [W-1:0] diff;
  logic         bOut;
  logic         busy;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bIn  (bIn),
    .diff (diff),
    .bOut (bOut),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {bOut, diff} is the (W+1)-bit wrap of a - b - bIn.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mbi);
    return {1'b0, ma} - {1'b0, mb} - (W + 1)'(mbi);
  endfunction

  // One start pulse, then wait for done and check latency, busy length and result.
  task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                       input string tag);
    int         edges;
    int         busyCnt;
    logic [W:0] exp;
    exp = model(ta, tb, tbi);
    @(negedge clk);
    a = ta; b = tb; bIn = tbi; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    edges   = 1;
    busyCnt = 0;
    while (!done && edges < 4 * W) begin
      if (busy) busyCnt++;
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, edges, W + 1);
    check({tag, " busy cycles"}, busyCnt, W);
    check({tag, " diff"}, 32'(diff), 32'(exp[W-1:0]));
    check({tag, " bOut"}, 32'(bOut), 32'(exp[W]));
    check({tag, " busy at done"}, 32'(busy), 0);
    @(negedge clk);
    check({tag, " done single pulse"}, 32'(done), 0);
  endtask

  initial begin
    int edges;
    int seen;

    rst = 1'b0; start = 1'b0; a = '0; b = '0; bIn = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset diff", 32'(diff), 0);
    check("reset bOut", 32'(bOut), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    runOp(4'd7, 4'd3, 1'b0, "basic");
    check("basic diff const", 32'(diff), 4);
    runOp(4'd3, 4'd7, 1'b0, "underflow");
    check("underflow diff const", 32'(diff), 12);
    check("underflow bOut const", 32'(bOut), 1);
    runOp(4'd0, 4'd0, 1'b1, "zero minus bin");
    check("zero minus bin diff const", 32'(diff), 15);
    runOp(4'd15, 4'd15, 1'b1, "all ones bin");
    check("all ones bin bOut const", 32'(bOut), 1);
    runOp(4'd15, 4'd0, 1'b0, "max minus zero");
    check("max minus zero diff const", 32'(diff), 15);

    // Input changes and a start during SHIFT must not disturb the operation.
    @(negedge clk);
    a = 4'd9; b = 4'd2; bIn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'd0;
    check("stable hold early", 32'(diff), 15);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    seen  = 0;
    while (!done && edges < 4 * W) begin
      if (diff !== 4'd15) seen++;
      @(negedge clk);
      edges++;
    end
    check("stable diff held in shift", seen, 0);
    check("stable done reached", 32'(done), 1);
    check("stable diff", 32'(diff), 7);
    check("stable bOut", 32'(bOut), 0);
    seen = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("no second op", seen, 0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 4'd5; b = 4'd1; bIn = 1'b0; start = 1'b1;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!done && edges < 4 * W);
    check("b2b first diff", 32'(diff), 4);
    check("b2b first bOut", 32'(bOut), 0);
    a = 4'd1; b = 4'd5;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!done && edges < 4 * W);
    check("b2b spacing", edges, W + 1);
    check("b2b second diff", 32'(diff), 12);
    check("b2b second bOut", 32'(bOut), 1);
    start = 1'b0;
    @(negedge clk);
    check("b2b done drops", 32'(done), 0);

    // Asynchronous reset two cycles into SHIFT.
    a = 4'd11; b = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset diff", 32'(diff), 0);
    check("midreset bOut", 32'(bOut), 0);
    check("midreset busy", 32'(busy), 0);
    check("midreset done", 32'(done), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midreset no done", seen, 0);
    runOp(4'd6, 4'd6, 1'b0, "after reset");

    for (int i = 0; i < 40; i++) begin
      runOp(4'($urandom), 4'($urandom), 1'($urandom), "random");
    end

    for (int i = 0; i < 512; i++) begin
      runOp(i[3:0], i[7:4], i[8], "sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
